// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: entries are allocated at request issue and filled later by
// in-order memory responses; the head is presented once its fill has landed.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc,
  input  logic [XLEN-1:0]    alloc_pc,
  input  logic               fill,
  input  logic [INSTR_W-1:0] fill_instr,
  input  logic               pop,
  output logic               head_valid,
  output logic [XLEN-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [CW-1:0]      alloc_cnt,
  output logic [CW-1:0]      filled_cnt
);

  logic [XLEN-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0]   filled;
  logic [AW-1:0]      alloc_ptr;
  logic [AW-1:0]      fill_ptr;
  logic [AW-1:0]      rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      rd_ptr     <= '0;
      filled     <= '0;
      alloc_cnt  <= '0;
      filled_cnt <= '0;
    end else if (flush) begin
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      rd_ptr     <= '0;
      filled     <= '0;
      alloc_cnt  <= '0;
      filled_cnt <= '0;
    end else begin
      if (alloc)
        alloc_ptr <= alloc_ptr + AW'(1);
      if (fill) begin
        fill_ptr         <= fill_ptr + AW'(1);
        filled[fill_ptr] <= 1'b1;
      end
      // The fill target is never the filled head, so these bit writes cannot collide.
      if (pop) begin
        rd_ptr         <= rd_ptr + AW'(1);
        filled[rd_ptr] <= 1'b0;
      end
      alloc_cnt  <= alloc_cnt + CW'(alloc) - CW'(pop);
      filled_cnt <= filled_cnt + CW'(fill) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc)
      pc_mem[alloc_ptr] <= alloc_pc;
    if (fill)
      instr_mem[fill_ptr] <= fill_instr;
  end

  // Gating by the filled bit keeps the outputs at zero while nothing valid is held.
  always_comb begin
    head_valid = filled[rd_ptr];
    head_pc    = head_valid ? pc_mem[rd_ptr] : '0;
    head_instr = head_valid ? instr_mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, request issue against queue capacity,
// and discard accounting for responses that belong to a flushed stream.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [XLEN-1:0]    instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   alloc_cnt;
  logic [CW-1:0]   filled_cnt;
  logic [CW:0]     in_flight;
  logic [CW:0]     outstanding;
  logic            issue;
  logic            rsp_ok;
  logic            fill;
  logic            pop;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Stale responses still occupy capacity until they drain, so they count against DEPTH.
  always_comb begin
    in_flight      = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
    outstanding    = {1'b0, CW'(alloc_cnt - filled_cnt)} + {1'b0, discard_cnt};
    imem_req_valid = !rst && !redirect_valid && (in_flight < (CW+1)'(DEPTH));
    imem_addr      = fetch_pc;
    issue          = imem_req_valid && imem_req_ready;
    rsp_ok         = imem_rsp_valid && (outstanding != '0);
    fill           = rsp_ok && (discard_cnt == '0) && !redirect_valid;
    pop            = instr_valid && instr_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fetch_pc <= RESET_PC;
    else if (redirect_valid)
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (issue)
      fetch_pc <= fetch_pc + XLEN'(4);
  end

  // On redirect every unanswered request becomes a discard, less any response landing now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      discard_cnt <= '0;
    else if (redirect_valid)
      discard_cnt <= CW'(outstanding - (CW+1)'(rsp_ok));
    else if (rsp_ok && (discard_cnt != '0))
      discard_cnt <= discard_cnt - CW'(1);
  end

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .alloc      (issue),
    .alloc_pc   (fetch_pc),
    .fill       (fill),
    .fill_instr (imem_rsp_data),
    .pop        (pop),
    .head_valid (instr_valid),
    .head_pc    (instr_pc),
    .head_instr (instr_data),
    .alloc_cnt  (alloc_cnt),
    .filled_cnt (filled_cnt)
  );

  rsp_without_request: assert property (
    @(posedge clk) disable iff (rst) imem_rsp_valid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order variable-latency memory model plus a
// stream-level reference of what decode must see, compared every cycle.
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          gen;
    int          due;
  } req_t;

  req_t        pending[$];
  logic [31:0] issued[$];
  logic [31:0] pops[$];
  int          applied = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gen = 0;
  int          live = 0;
  int          ready_live = 0;
  logic        mem_ready = 1'b1;
  logic        dec_ready = 1'b1;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] exp_head = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F13;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr_data", instr_data, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_addr", imem_addr, RESET_PC);
    pending.delete();
    issued.delete();
    pops.delete();
    gen++;
    live       = 0;
    ready_live = 0;
    exp_fetch  = RESET_PC;
    exp_head   = RESET_PC;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare against the reference, then advance it.
  task automatic tick(input logic redir, input logic [31:0] tgt);
    int   stale;
    logic rsp;
    logic exp_rv;
    logic exp_iv;
    req_t r;
    stale = 0;
    @(negedge clk);
    foreach (pending[i]) if (pending[i].gen != gen) stale++;
    rsp            = (pending.size() > 0) && (pending[0].due <= cyc);
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_req_ready = mem_ready;
    instr_ready    = dec_ready;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pending[0].addr) : $urandom;
    #1;
    exp_rv = !redir && ((live + stale) < DEPTH);
    exp_iv = ready_live > 0;
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    check("imem_addr", imem_addr, exp_fetch);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
    if (exp_iv) begin
      check("instr_pc", instr_pc, exp_head);
      check("instr_data", instr_data, mem_word(exp_head));
    end
    if (imem_req_valid && imem_req_ready) issued.push_back(imem_addr);
    if (instr_valid && instr_ready) pops.push_back(instr_pc);
    if (exp_iv && dec_ready) begin
      exp_head += 32'd4;
      ready_live--;
      live--;
    end
    if (rsp) begin
      r = pending.pop_front();
      if (r.gen == gen) ready_live++;
    end
    if (exp_rv && mem_ready) begin
      r.addr = exp_fetch;
      r.gen  = gen;
      r.due  = cyc + lat;
      pending.push_back(r);
      live++;
      exp_fetch += 32'd4;
    end
    if (redir) begin
      gen++;
      live       = 0;
      ready_live = 0;
      exp_fetch  = {tgt[31:2], 2'b00};
      exp_head   = exp_fetch;
    end
    cyc++;
  endtask

  initial begin
    int n;
    do_reset();

    // Streaming, one-cycle memory, decode always ready; then a short memory stall.
    lat = 1; mem_ready = 1'b1; dec_ready = 1'b1;
    repeat (12) tick(1'b0, 32'h0);
    check("s1_issued", 32'(issued.size()), 32'd12);
    check("s1_pops", 32'(pops.size()), 32'd10);
    check("s1_pop0", pops[0], 32'h0);
    check("s1_pop1", pops[1], 32'h4);
    check("s1_pop2", pops[2], 32'h8);
    mem_ready = 1'b0;
    repeat (3) tick(1'b0, 32'h0);
    mem_ready = 1'b1;
    repeat (6) tick(1'b0, 32'h0);

    // Decode stalled: queue fills to DEPTH, then one pop frees a slot.
    do_reset();
    lat = 1; dec_ready = 1'b0;
    repeat (8) tick(1'b0, 32'h0);
    check("s2_issued", 32'(issued.size()), 32'd4);
    check("s2_last", issued[3], 32'hC);
    dec_ready = 1'b1;
    tick(1'b0, 32'h0);
    check("s2_hold", 32'(issued.size()), 32'd4);
    tick(1'b0, 32'h0);
    check("s2_next", issued[4], 32'h10);

    // Three-cycle memory with three requests outstanding at redirect.
    do_reset();
    lat = 3; dec_ready = 1'b1;
    repeat (3) tick(1'b0, 32'h0);
    tick(1'b1, 32'h100);
    check("s3_none_before", 32'(pops.size()), 32'd0);
    repeat (10) tick(1'b0, 32'h0);
    check("s3_first", pops[0], 32'h100);
    check("s3_second", pops[1], 32'h104);

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat = 1; dec_ready = 1'b1;
    repeat (5) tick(1'b0, 32'h0);
    tick(1'b1, 32'h200);
    check("s4_pop_at_redir", pops[3], 32'hC);
    repeat (8) tick(1'b0, 32'h0);
    check("s4_target", pops[4], 32'h200);
    check("s4_target_next", pops[5], 32'h204);

    // Address wrap and unaligned redirect target.
    do_reset();
    lat = 2; dec_ready = 1'b1;
    tick(1'b1, 32'hFFFF_FFFC);
    repeat (8) tick(1'b0, 32'h0);
    check("s5_wrap0", pops[0], 32'hFFFF_FFFC);
    check("s5_wrap1", pops[1], 32'h0);
    tick(1'b1, 32'h102);
    n = pops.size();
    repeat (8) tick(1'b0, 32'h0);
    check("s5_align", pops[n], 32'h100);

    // Reset asserted with two requests outstanding.
    do_reset();
    lat = 3; dec_ready = 1'b1;
    repeat (2) tick(1'b0, 32'h0);
    do_reset();
    lat = 1;
    tick(1'b0, 32'h0);
    check("s6_first_addr", issued[0], RESET_PC);
    repeat (6) tick(1'b0, 32'h0);
    check("s6_pop0", pops[0], RESET_PC);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
